bin2bcd_seq: RTL and testbench

//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter.

---
 rtl/bin2bcd_seq.sv | 157 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with saturation and a registered, display-stable output.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    function automatic int unsigned pow10_minus1(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    // Enough accumulator digits that every IN_W-bit value converts exactly.
    localparam int unsigned ACC_DIG_RAW = (IN_W * 301 + 999) / 1000;
    localparam int unsigned ACC_DIGITS  = (ACC_DIG_RAW > DIGITS) ? ACC_DIG_RAW : DIGITS;
    localparam int unsigned ACC_W       = 4 * ACC_DIGITS;
    localparam int unsigned OUT_W       = 4 * DIGITS;
    localparam int unsigned CNT_W       = $clog2(IN_W + 1);
    localparam int unsigned MAX_VAL     = pow10_minus1(DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [IN_W-1:0]   bin_q,      bin_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              ovf_next_q, ovf_next_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [OUT_W-1:0]  bcd_q,      bcd_d;
    logic              ovf_q,      ovf_d;
    logic [DIGITS-1:0] blank_q,    blank_d;

    logic [ACC_W-1:0]  acc_adj;
    logic [DIGITS-1:0] blank_calc;

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < ACC_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    // Blank digit i when it and every higher exported digit are zero; units always shown.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_calc = '0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_above    = zero_above && (acc_q[4*i +: 4] == 4'h0);
            blank_calc[i] = zero_above;
        end
    end
`else
    always_comb begin
        blank_calc = '0;
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    bin_d      = bin_in;
                    cnt_d      = '0;
                    ovf_next_d = (32'(bin_in) > MAX_VAL);
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = ACC_W'({acc_adj, bin_q[IN_W-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                ovf_d   = ovf_next_q;
                bcd_d   = ovf_next_q ? {DIGITS{4'h9}} : acc_q[OUT_W-1:0];
                blank_d = ovf_next_q ? '0 : blank_calc;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (IN_W=16, DIGITS=4): directed vectors, start burst, mid-conversion reset.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;
    logic [3:0]  blank;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   next_acc = 0;

    logic [15:0] last_bcd   = '0;
    logic        last_ovf   = 1'b0;
    logic [3:0]  last_blank = '0;

    bin2bcd_seq #(.IN_W(16), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_model(input int unsigned v);
        exp_t e;
        int unsigned d0, d1, d2, d3;
        e.cyc = 0;
        if (v > 9999) begin
            e.bcd   = 16'h9999;
            e.ovf   = 1'b1;
            e.blank = 4'b0000;
        end else begin
            d0 = v % 10;
            d1 = (v / 10) % 10;
            d2 = (v / 100) % 10;
            d3 = (v / 1000) % 10;
            e.bcd   = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
            e.ovf   = 1'b0;
            e.blank = 4'b0000;
`ifdef BIN2BCD_BLANK_EN
            e.blank[3] = (d3 == 0);
            e.blank[2] = e.blank[3] && (d2 == 0);
            e.blank[1] = e.blank[2] && (d1 == 0);
`endif
        end
        return e;
    endfunction

    // Acceptance model: a start is taken once per 18 cycles, expected done 17 edges later.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            next_acc = 0;
        end else if (start && cyc >= next_acc) begin
            e     = ref_model(int'(bin_in));
            e.cyc = cyc + 18;
            sb.push_back(e);
            next_acc = cyc + 18;
        end
        cyc = cyc + 1;
    end

    // Monitor: pops the scoreboard on done, otherwise checks outputs are held.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_bcd   = '0;
            last_ovf   = 1'b0;
            last_blank = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("sb_bcd", 32'(bcd_out), 32'(e.bcd));
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
                chk("sb_blank", 32'(blank), 32'(e.blank));
                chk("busy_low_on_done", 32'(busy), 32'd0);
            end
            last_bcd   = bcd_out;
            last_ovf   = ovf;
            last_blank = blank;
        end else begin
            chk("hold_out", {11'd0, last_ovf, last_blank, last_bcd}, {11'd0, ovf, blank, bcd_out});
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue one conversion and compare against the given expected result.
    task automatic convert(input logic [15:0] v, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input logic [3:0] exp_blank);
        bit ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'hDEAD;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(ok);
        if (ok) begin
            chk("dir_bcd", 32'(bcd_out), 32'(exp_bcd));
            chk("dir_ovf", 32'(ovf), 32'(exp_ovf));
            chk("dir_blank", 32'(blank), 32'(exp_blank));
        end
    endtask

    localparam bit BLANK_ON =
`ifdef BIN2BCD_BLANK_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [15:0] v;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'd1234,  16'h1234, 1'b0, 4'b0000},
        '{16'd9999,  16'h9999, 1'b0, 4'b0000},
        '{16'd10000, 16'h9999, 1'b1, 4'b0000},
        '{16'd65535, 16'h9999, 1'b1, 4'b0000},
        '{16'd0,     16'h0000, 1'b0, 4'b1110},
        '{16'd42,    16'h0042, 1'b0, 4'b1100},
        '{16'd7,     16'h0007, 1'b0, 4'b1110},
        '{16'd500,   16'h0500, 1'b0, 4'b1000},
        '{16'd10,    16'h0010, 1'b0, 4'b1100}
    };

    initial begin
        exp_t e;
        bit   ok;
        logic [15:0] rv;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            convert(vecs[i].v, vecs[i].bcd, vecs[i].ovf, BLANK_ON ? vecs[i].blank : 4'b0000);
        end

        // Start held high with a new bin_in every cycle; only IDLE samples are converted.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start  = 1'b1;
            bin_in = 16'(i * 1111 + 3);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("burst_drained", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 20; i++) begin
            rv = 16'($urandom_range(0, 65535));
            e  = ref_model(int'(rv));
            convert(rv, e.bcd, e.ovf, e.blank);
        end

        // Reset in the middle of a conversion must clear outputs and cancel done.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_bcd_after", 32'(bcd_out), 32'd0);

        convert(16'd1234, 16'h1234, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
